// File: rtl/stream_pkg.sv
// stream_pkg
//   Types shared by the stream link blocks (stream_arbiter / stream_demux):
//   - demux_state_t : packet-tracking state of the demultiplexer
//   - beat_t        : one beat at the default link widths (data, qos, last)
package stream_pkg;

  localparam int unsigned BEAT_DATA_WIDTH = 8;
  localparam int unsigned BEAT_QOS_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } demux_state_t;

  typedef struct packed {
    logic [BEAT_DATA_WIDTH-1:0] data;
    logic [BEAT_QOS_WIDTH-1:0]  qos;
    logic                       last;
  } beat_t;

endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux_slot
//   One-deep output register stage of stream_demux.
//   Ports:
//     clk, rst_n           clock, async active-low reset
//     i_load               accept a beat this cycle (only asserted when o_can_take)
//     i_data/i_qos/i_last  beat to load
//     i_ready              downstream ready
//     o_valid/o_data/o_qos/o_last  registered beat towards downstream
//     o_can_take           slot empty or being drained this cycle
module stream_demux_slot #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load,
  input  logic [T_DATA_WIDTH-1:0] i_data,
  input  logic [T_QOS_WIDTH-1:0]  i_qos,
  input  logic                    i_last,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [T_DATA_WIDTH-1:0] o_data,
  output logic [T_QOS_WIDTH-1:0]  o_qos,
  output logic                    o_last,
  output logic                    o_can_take
);

  logic                    r_valid;
  logic [T_DATA_WIDTH-1:0] r_data;
  logic [T_QOS_WIDTH-1:0]  r_qos;
  logic                    r_last;

  assign o_can_take = !r_valid || i_ready;

  // Load wins over drain so a simultaneous load/drain keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_qos   <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_qos   <= i_qos;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_qos   = r_qos;
  assign o_last  = r_last;

endmodule

// File: rtl/stream_demux.sv
// stream_demux
//   Packet-level demultiplexer: routes each whole packet of the input stream
//   to the output selected by the id on its first beat. Packets with an
//   out-of-range id are swallowed and flagged on drop_o.
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     s_data_i/s_qos_i/s_id_i/s_last_i    input beat
//     s_valid_i, s_ready_o                input handshake
//     m_data_o/m_qos_o/m_last_o           per-output beat (unpacked arrays)
//     m_valid_o, m_ready_i                per-output handshake
//     drop_o                              pulse after last beat of a dropped packet
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | next accepted beat starts a packet; s_id_i selects
//   ST_ROUTE | packet in progress to r_cur_id
//   ST_DROP  | packet in progress with invalid id, beats discarded
module stream_demux
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS_WIDTH  = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID_WIDTH   = $clog2(STREAM_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS_WIDTH-1:0]  s_qos_i,
  input  logic [T_ID_WIDTH-1:0]   s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [STREAM_COUNT],
  output logic [T_QOS_WIDTH-1:0]  m_qos_o  [STREAM_COUNT],
  output logic [STREAM_COUNT-1:0] m_last_o,
  output logic [STREAM_COUNT-1:0] m_valid_o,
  input  logic [STREAM_COUNT-1:0] m_ready_i,
  output logic                    drop_o
);

  demux_state_t            r_state;
  demux_state_t            w_state_nxt;
  logic [T_ID_WIDTH-1:0]   r_cur_id;
  logic                    r_drop;

  logic                    w_id_ok;
  logic                    w_dropping;
  logic [T_ID_WIDTH-1:0]   w_dest;
  logic                    w_dest_can;
  logic                    w_accept;
  logic [STREAM_COUNT-1:0] w_can_take;
  logic [STREAM_COUNT-1:0] w_load;

  assign w_id_ok = (32'(s_id_i) < 32'(STREAM_COUNT));
  assign w_dest  = (r_state == ST_ROUTE) ? r_cur_id : s_id_i;

  // Select by compare rather than direct indexing: w_dest may exceed the
  // slot range when an invalid id is on the bus.
  always_comb begin
    w_dest_can = 1'b0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      if (w_dest == T_ID_WIDTH'(k)) w_dest_can = w_can_take[k];
    end
  end

  assign s_ready_o = w_dropping || w_dest_can;
  assign w_accept  = s_valid_i && s_ready_o;

  always_comb begin
    w_load = '0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      w_load[k] = w_accept && !w_dropping && (w_dest == T_ID_WIDTH'(k));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dropping  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dropping = !w_id_ok;
        if (w_accept && !s_last_i) w_state_nxt = w_id_ok ? ST_ROUTE : ST_DROP;
      end
      ST_ROUTE: begin
        if (w_accept && s_last_i) w_state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        w_dropping = 1'b1;
        if (w_accept && s_last_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cur_id <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_accept && w_dropping && s_last_i;
      if (r_state == ST_IDLE && w_accept && w_id_ok) r_cur_id <= s_id_i;
    end
  end

  assign drop_o = r_drop;

  for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_slot
    stream_demux_slot #(
      .T_DATA_WIDTH(T_DATA_WIDTH),
      .T_QOS_WIDTH (T_QOS_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load[g]),
      .i_data    (s_data_i),
      .i_qos     (s_qos_i),
      .i_last    (s_last_i),
      .i_ready   (m_ready_i[g]),
      .o_valid   (m_valid_o[g]),
      .o_data    (m_data_o[g]),
      .o_qos     (m_qos_o[g]),
      .o_last    (m_last_o[g]),
      .o_can_take(w_can_take[g])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

  localparam int DW = 8;
  localparam int QW = 4;
  localparam int SC = 3;
  localparam int IW = 2;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic [QW-1:0] s_qos;
  logic [IW-1:0] s_id;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data [SC];
  logic [QW-1:0] m_qos  [SC];
  logic [SC-1:0] m_last;
  logic [SC-1:0] m_valid;
  logic [SC-1:0] m_ready;
  logic          drop;

  int n_chk;
  int n_err;

  stream_demux #(
    .T_DATA_WIDTH(DW),
    .T_QOS_WIDTH (QW),
    .STREAM_COUNT(SC),
    .T_ID_WIDTH  (IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data_i (s_data),
    .s_qos_i  (s_qos),
    .s_id_i   (s_id),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_qos_o  (m_qos),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .drop_o   (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d,
                       input logic [QW-1:0] q, input logic l);
    s_valid = v;
    s_id    = id;
    s_data  = d;
    s_qos   = q;
    s_last  = l;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n   = 1'b0;
    m_ready = 3'b111;
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    step();
    step();
    check_eq("rst_valid", 32'(m_valid), 32'h0);
    check_eq("rst_data0", 32'(m_data[0]), 32'h0);
    check_eq("rst_qos1", 32'(m_qos[1]), 32'h0);
    check_eq("rst_last", 32'(m_last), 32'h0);
    check_eq("rst_drop", 32'(drop), 32'h0);
    check_eq("rst_ready", 32'(s_ready), 32'h1);
    rst_n = 1'b1;
    step();

    // basic route
    drive(1'b1, 2'd0, 8'hA1, 4'd3, 1'b0);
    #1 check_eq("basic_rdyA", 32'(s_ready), 32'h1);
    step();
    check_eq("basic_vA", 32'(m_valid), 32'b001);
    check_eq("basic_dA", 32'(m_data[0]), 32'hA1);
    check_eq("basic_qA", 32'(m_qos[0]), 32'h3);
    check_eq("basic_lA", 32'(m_last[0]), 32'h0);
    drive(1'b1, 2'd0, 8'hB2, 4'd3, 1'b1);
    step();
    check_eq("basic_vB", 32'(m_valid), 32'b001);
    check_eq("basic_dB", 32'(m_data[0]), 32'hB2);
    check_eq("basic_lB", 32'(m_last[0]), 32'h1);
    drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    step();
    check_eq("basic_drain", 32'(m_valid), 32'b000);

    // id locked mid-packet
    drive(1'b1, 2'd1, 8'hC3, 4'd1, 1'b0);
    step();
    check_eq("lock_vC", 32'(m_valid), 32'b010);
    check_eq("lock_dC", 32'(m_data[1]), 32'hC3);
    drive(1'b1, 2'd0, 8'hD4, 4'd1, 1'b1);
    step();
    check_eq("lock_vD", 32'(m_valid), 32'b010);
    check_eq("lock_dD", 32'(m_data[1]), 32'hD4);
    check_eq("lock_lD", 32'(m_last[1]), 32'h1);
    // FSM back in IDLE: a fresh single beat follows its own id
    drive(1'b1, 2'd2, 8'h77, 4'd5, 1'b1);
    step();
    check_eq("idle_v2", 32'(m_valid), 32'b100);
    check_eq("idle_d2", 32'(m_data[2]), 32'h77);
    check_eq("idle_q2", 32'(m_qos[2]), 32'h5);
    drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    step();

    // per-output backpressure
    m_ready = 3'b101;
    drive(1'b1, 2'd1, 8'hE5, 4'd2, 1'b0);
    #1 check_eq("bp_rdyE", 32'(s_ready), 32'h1);
    step();
    check_eq("bp_vE", 32'(m_valid), 32'b010);
    check_eq("bp_dE", 32'(m_data[1]), 32'hE5);
    drive(1'b1, 2'd1, 8'hF6, 4'd2, 1'b1);
    #1 check_eq("bp_rdyF0", 32'(s_ready), 32'h0);
    step();
    check_eq("bp_holdE", 32'(m_data[1]), 32'hE5);
    check_eq("bp_holdv", 32'(m_valid), 32'b010);
    check_eq("bp_holdl", 32'(m_last[1]), 32'h0);
    check_eq("bp_rdyF1", 32'(s_ready), 32'h0);
    m_ready = 3'b111;
    #1 check_eq("bp_rdyF2", 32'(s_ready), 32'h1);
    step();
    check_eq("bp_vF", 32'(m_valid), 32'b010);
    check_eq("bp_dF", 32'(m_data[1]), 32'hF6);
    check_eq("bp_lF", 32'(m_last[1]), 32'h1);
    check_eq("bp_qF", 32'(m_qos[1]), 32'h2);
    drive(1'b1, 2'd0, 8'h11, 4'd7, 1'b1);
    step();
    check_eq("bp_s0v", 32'(m_valid), 32'b001);
    check_eq("bp_s0d", 32'(m_data[0]), 32'h11);
    drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    step();
    check_eq("bp_idle", 32'(m_valid), 32'b000);

    // invalid id, two beats; id on the last beat is ignored
    drive(1'b1, 2'd3, 8'h08, 4'd0, 1'b0);
    #1 check_eq("drop_rdy8", 32'(s_ready), 32'h1);
    step();
    check_eq("drop_v8", 32'(m_valid), 32'b000);
    check_eq("drop_p8", 32'(drop), 32'h0);
    drive(1'b1, 2'd0, 8'h09, 4'd0, 1'b1);
    #1 check_eq("drop_rdy9", 32'(s_ready), 32'h1);
    step();
    check_eq("drop_v9", 32'(m_valid), 32'b000);
    check_eq("drop_p9", 32'(drop), 32'h1);
    drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    step();
    check_eq("drop_pend", 32'(drop), 32'h0);
    // single-beat invalid packet
    drive(1'b1, 2'd3, 8'h0A, 4'd0, 1'b1);
    step();
    check_eq("drop1_p", 32'(drop), 32'h1);
    check_eq("drop1_v", 32'(m_valid), 32'b000);
    drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    step();
    check_eq("drop1_pend", 32'(drop), 32'h0);

    // single-beat packets back to back
    drive(1'b1, 2'd0, 8'h55, 4'd1, 1'b1);
    #1 check_eq("sb_rdy55", 32'(s_ready), 32'h1);
    step();
    check_eq("sb_v55", 32'(m_valid), 32'b001);
    check_eq("sb_d55", 32'(m_data[0]), 32'h55);
    drive(1'b1, 2'd1, 8'h66, 4'd1, 1'b1);
    #1 check_eq("sb_rdy66", 32'(s_ready), 32'h1);
    step();
    check_eq("sb_v66", 32'(m_valid), 32'b010);
    check_eq("sb_d66", 32'(m_data[1]), 32'h66);
    drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    step();

    // reset mid-packet
    drive(1'b1, 2'd1, 8'h9A, 4'd4, 1'b0);
    step();
    check_eq("rm_v1", 32'(m_valid), 32'b010);
    drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_eq("rm_async", 32'(m_valid), 32'b000);
    step();
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 8'h3C, 4'd6, 1'b1);
    step();
    check_eq("rm_v0", 32'(m_valid), 32'b001);
    check_eq("rm_d0", 32'(m_data[0]), 32'h3C);
    drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
